neuron_mac: RTL and testbench

Upstream stage of the sigmoid activation ROM in a neuron datapath. Accepts a stream of signed 8-bit input/weight pairs, multiply-accumulates them, then scales and saturates the sum to a signed 8-bit pre-activation. It maps that value to an 8-bit ROM address, performs one strobed read of the activation ROM, and presents the returned activation on a valid/ready output.

---
 rtl/neuron_mac_pkg.sv | 19 +
 rtl/neuron_mac_sat_scale.sv | 32 +++
 rtl/neuron_mac.sv | 132 +++++++++++++
 tb/tb_neuron_mac.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/neuron_mac_pkg.sv
// Shared types and constants for the neuron_mac MAC / activation-ROM front end.
package neuron_mac_pkg;

  localparam int ROM_ADDR_W = 8;
  localparam int DATA_W     = 8;

  localparam logic [ROM_ADDR_W-1:0] OFFSET_BIN = 8'h80;
  localparam logic signed [DATA_W-1:0] SAT_MAX = 8'sd127;
  localparam logic signed [DATA_W-1:0] SAT_MIN = -8'sd128;

  typedef enum logic [2:0] {
    ST_ACC,
    ST_SCALE,
    ST_ROM_REQ,
    ST_ROM_WAIT,
    ST_OUT
  } state_e;

endpackage

// File: rtl/neuron_mac_sat_scale.sv
// Combinational scale/saturate of the biased sum and mapping to an offset-binary ROM address.
module sat_scale
  import neuron_mac_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int SHIFT = 7
) (
  input  logic signed [ACC_W-1:0]      sum_i,
  output logic        [ROM_ADDR_W-1:0] addr_o,
  output logic                         sat_o
);

  logic signed [ACC_W-1:0]  v;
  logic signed [DATA_W-1:0] clamped;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    v       = sum_i >>> SHIFT;
    clamped = v[DATA_W-1:0];
    sat_o   = 1'b0;
    if (v > ACC_W'(SAT_MAX)) begin
      clamped = SAT_MAX;
      sat_o   = 1'b1;
    end else if (v < ACC_W'(SAT_MIN)) begin
      clamped = SAT_MIN;
      sat_o   = 1'b1;
    end
  end

  assign addr_o = clamped ^ OFFSET_BIN;

endmodule

// File: rtl/neuron_mac.sv
// Neuron MAC: accumulate x*w beats, scale/saturate, one strobed activation-ROM read, valid/ready out.
// Optional bias input enabled by defining NEURON_MAC_BIAS_EN.
module neuron_mac
  import neuron_mac_pkg::*;
#(
  parameter int MAX_TERMS = 64,
  parameter int ACC_W     = 24,
  parameter int SHIFT     = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_W-1:0]     in_x,
  input  logic signed [DATA_W-1:0]     in_w,
  input  logic                         in_last,
`ifdef NEURON_MAC_BIAS_EN
  input  logic signed [DATA_W-1:0]     bias,
`endif
  output logic        [ROM_ADDR_W-1:0] rom_add,
  output logic                         rom_cs,
  output logic                         rom_read,
  input  logic        [DATA_W-1:0]     rom_out,
  output logic                         y_valid,
  input  logic                         y_ready,
  output logic        [DATA_W-1:0]     y,
  output logic                         sat
);

  localparam int CNT_W = $clog2(MAX_TERMS);

  state_e                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    scale_ph_q;
  logic [ROM_ADDR_W-1:0]   rom_add_q;
  logic                    rom_cs_q;
  logic                    rom_read_q;
  logic [DATA_W-1:0]       y_q;
  logic                    y_valid_q;
  logic                    sat_q;

  logic signed [15:0]           prod;
  logic signed [ACC_W-1:0]      bias_term;
  logic        [ROM_ADDR_W-1:0] scaled_addr;
  logic                         scaled_sat;

  assign prod = 16'(in_x) * 16'(in_w);

`ifdef NEURON_MAC_BIAS_EN
  assign bias_term = ACC_W'(bias) <<< SHIFT;
`else
  assign bias_term = '0;
`endif

  sat_scale #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_sat_scale (
    .sum_i  (acc_q + bias_term),
    .addr_o (scaled_addr),
    .sat_o  (scaled_sat)
  );

  // SCALE runs two cycles: the address is registered first, then the strobe rises a cycle
  // later so rom_add is already stable when the ROM latches on the rising edge of rom_cs.
  // NOTE: all state below is sequential and uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACC;
      acc_q      <= '0;
      cnt_q      <= '0;
      scale_ph_q <= 1'b0;
      rom_add_q  <= '0;
      rom_cs_q   <= 1'b0;
      rom_read_q <= 1'b0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            acc_q <= acc_q + ACC_W'(prod);
            cnt_q <= cnt_q + CNT_W'(1);
            if (in_last || cnt_q == CNT_W'(MAX_TERMS - 1)) state_q <= ST_SCALE;
          end
        end
        ST_SCALE: begin
          if (!scale_ph_q) begin
            rom_add_q  <= scaled_addr;
            sat_q      <= scaled_sat;
            scale_ph_q <= 1'b1;
          end else begin
            acc_q      <= '0;
            cnt_q      <= '0;
            scale_ph_q <= 1'b0;
            rom_cs_q   <= 1'b1;
            rom_read_q <= 1'b1;
            state_q    <= ST_ROM_REQ;
          end
        end
        ST_ROM_REQ: begin
          rom_cs_q <= 1'b0;
          state_q  <= ST_ROM_WAIT;
        end
        ST_ROM_WAIT: begin
          y_q        <= rom_out;
          rom_read_q <= 1'b0;
          y_valid_q  <= 1'b1;
          state_q    <= ST_OUT;
        end
        ST_OUT: begin
          if (y_ready) begin
            y_valid_q <= 1'b0;
            state_q   <= ST_ACC;
          end
        end
        default: state_q <= ST_ACC;
      endcase
    end
  end

  assign in_ready = (state_q == ST_ACC);
  assign rom_add  = rom_add_q;
  assign rom_cs   = rom_cs_q;
  assign rom_read = rom_read_q;
  assign y        = y_q;
  assign y_valid  = y_valid_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with a behavioural sigmoid-like ROM (y = 127 - signed(addr ^ 8'h80)).
module tb_neuron_mac;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] in_x = '0;
  logic signed [7:0] in_w = '0;
  logic              in_last = 1'b0;
`ifdef NEURON_MAC_BIAS_EN
  logic signed [7:0] bias = '0;
`endif
  logic [7:0]        rom_add;
  logic              rom_cs;
  logic              rom_read;
  logic [7:0]        rom_out = '0;
  logic              y_valid;
  logic              y_ready = 1'b0;
  logic [7:0]        y;
  logic              sat;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cs_cnt = 0;
  int k_edge = 0;
  int cs_base = 0;
  logic cs_rd = 1'b0;

  neuron_mac dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_w     (in_w),
    .in_last  (in_last),
`ifdef NEURON_MAC_BIAS_EN
    .bias     (bias),
`endif
    .rom_add  (rom_add),
    .rom_cs   (rom_cs),
    .rom_read (rom_read),
    .rom_out  (rom_out),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .y        (y),
    .sat      (sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] rom_model(input logic [7:0] a);
    logic signed [7:0] p;
    p = a ^ 8'h80;
    return 8'(127 - int'(p));
  endfunction

  always @(posedge rom_cs) begin
    cs_cnt++;
    rom_out <= rom_model(rom_add);
  end
  always @(negedge rom_cs) cs_rd = rom_read;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic send(input logic signed [7:0] x, input logic signed [7:0] w, input logic last);
    in_valid = 1'b1;
    in_x     = x;
    in_w     = w;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    k_edge   = cyc;
    cs_base  = cs_cnt;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] e_addr, input logic [7:0] e_y,
                            input logic e_sat, input int hold);
    int n = 0;
    while (!y_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_yvalid"}, y_valid, 1);
    check({tag, "_latency"}, cyc - k_edge, 4);
    check({tag, "_addr"}, rom_add, e_addr);
    check({tag, "_y"}, y, e_y);
    check({tag, "_sat"}, sat, e_sat);
    check({tag, "_cs_pulses"}, cs_cnt - cs_base, 1);
    check({tag, "_read_during_cs"}, cs_rd, 1);
    check({tag, "_read_dropped"}, rom_read, 0);
    check({tag, "_in_ready_busy"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_x     = 8'sd100;
      in_w     = 8'sd100;
      @(posedge clk);
      #1;
      check({tag, "_hold_y"}, y, e_y);
      check({tag, "_hold_valid"}, y_valid, 1);
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end
    in_valid = 1'b0;
    if (hold > 0) check({tag, "_hold_cs_pulses"}, cs_cnt - cs_base, 1);
    y_ready = 1'b1;
    @(posedge clk);
    #1;
    y_ready = 1'b0;
    check({tag, "_valid_cleared"}, y_valid, 0);
    check({tag, "_in_ready_after"}, in_ready, 1);
  endtask

  initial begin
    #3;
    check("reset_rom_cs", rom_cs, 0);
    check("reset_rom_read", rom_read, 0);
    check("reset_rom_add", rom_add, 0);
    check("reset_y_valid", y_valid, 0);
    check("reset_y", y, 0);
    check("reset_sat", sat, 0);
    #9 rst_n = 1'b1;
    check("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // 10*20 = 200 -> v = 1 -> addr 129, y 126
    send(8'sd10, 8'sd20, 1'b1);
    expect_out("t1", 8'd129, 8'd126, 1'b0, 0);

    // 4 * 127*127 = 64516 -> v = 504, clamps to 127
    for (int i = 0; i < 4; i++) send(8'sd127, 8'sd127, i == 3);
    expect_out("t2", 8'd255, 8'd0, 1'b1, 0);

    // -128*127 = -16256 -> v = -127 -> addr 1, y 254
    send(-8'sd128, 8'sd127, 1'b1);
    expect_out("t3a", 8'd1, 8'd254, 1'b0, 0);

    // back-pressure with in_valid held high while busy; extra beats must be ignored
    send(8'sd10, 8'sd20, 1'b1);
    expect_out("t4", 8'd129, 8'd126, 1'b0, 5);

    send(8'sd0, 8'sd5, 1'b1);
    expect_out("t3b", 8'd128, 8'd127, 1'b0, 0);

    // 64 beats without in_last: the 64th closes the neuron, acc = 64 -> v = 0
    for (int i = 0; i < 63; i++) send(8'sd1, 8'sd1, 1'b0);
    check("t5_ready_before_64th", in_ready, 1);
    send(8'sd1, 8'sd1, 1'b0);
    check("t5_closed_by_count", in_ready, 0);
    expect_out("t5", 8'd128, 8'd127, 1'b0, 0);

    // abandon a neuron mid-accumulation with an asynchronous reset
    for (int i = 0; i < 3; i++) send(8'sd100, 8'sd100, 1'b0);
    cs_base = cs_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("t5r_rom_add", rom_add, 0);
    check("t5r_y", y, 0);
    check("t5r_y_valid", y_valid, 0);
    check("t5r_rom_cs", rom_cs, 0);
    check("t5r_in_ready", in_ready, 1);
    #14 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("t5r_no_strobe", cs_cnt - cs_base, 0);
    check("t5r_no_valid", y_valid, 0);
    send(8'sd10, 8'sd20, 1'b1);
    expect_out("t5r_fresh", 8'd129, 8'd126, 1'b0, 0);

`ifdef NEURON_MAC_BIAS_EN
    // bias 3 -> 3<<<7 = 384 -> v = 3 -> addr 131, y 124
    bias = 8'sd3;
    send(8'sd0, 8'sd7, 1'b1);
    expect_out("t6", 8'd131, 8'd124, 1'b0, 0);
    bias = 8'sd0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
